// File: rtl/brc_pkg.sv
// Shared types for the iterative branch comparator: FSM states, funct3 codes, branch decode.
// Latency: none (package only).
// Backpressure: n/a.
package brc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Branch decision from the final compare flags; unused funct codes never branch.
    function automatic logic br_decide(input logic [2:0] funct, input logic less, input logic equal);
        logic taken;
        case (funct)
            BEQ:        taken = equal;
            BNE:        taken = ~equal;
            BLT, BLTU:  taken = less;
            BGE, BGEU:  taken = ~less;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// Unsigned compare of one operand chunk: lt = a < b, eq = a == b.
// Latency: purely combinational.
// Backpressure: n/a.
module brc_chunk_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/brc_iter.sv
// Multi-cycle branch/SLT comparator: walks operands CHUNK bits per cycle from the MSB chunk down.
// Latency: N+1 cycles from accept to o_valid; with BRC_ITER_EARLY_EXIT_EN, k+2 for first difference at chunk k.
// Backpressure: result held in DONE until i_ready; a new request may be accepted in the same cycle.
module brc_iter
    import brc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [WIDTH-1:0] i_imm,
    input  logic             i_imm_sel,
    input  logic             i_br_un,
    input  logic [2:0]       i_funct,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal,
    output logic             o_br_taken
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_nx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       funct_q;
    logic [IW-1:0]    idx_q;
    logic             decided_q;
    logic             less_q;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             c_lt, c_eq;
    logic             accept;
    logic             last;
    logic             fin_less, fin_eq;

    assign o_ready = ((state_q == IDLE) | ((state_q == DONE) & i_ready)) & ~i_flush & ~i_rst;
    assign accept  = i_valid & o_ready;

    assign a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];

    brc_chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (c_lt),
        .eq (c_eq)
    );

`ifdef BRC_ITER_EARLY_EXIT_EN
    assign last = (idx_q == '0) | (~decided_q & ~c_eq);
`else
    assign last = (idx_q == '0);
`endif

    // Final flags as they stand after the current chunk; the first differing chunk wins.
    always_comb begin
        fin_less = less_q;
        fin_eq   = 1'b0;
        if (!decided_q) begin
            if (!c_eq) begin
                fin_less = c_lt;
            end else begin
                fin_less = 1'b0;
                fin_eq   = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_nx;
    end

    // Next-state decode; flush overrides everything.
    always_comb begin
        state_nx = state_q;
        if (i_flush) begin
            state_nx = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_nx = CMP;
                CMP:  if (last)   state_nx = DONE;
                DONE: if (i_ready) state_nx = accept ? CMP : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Operand capture, chunk walk and registered result flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q        <= '0;
            b_q        <= '0;
            funct_q    <= '0;
            idx_q      <= '0;
            decided_q  <= 1'b0;
            less_q     <= 1'b0;
            o_valid    <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
            o_br_taken <= 1'b0;
        end else if (i_flush) begin
            decided_q  <= 1'b0;
            less_q     <= 1'b0;
            o_valid    <= 1'b0;
            o_br_less  <= 1'b0;
            o_br_equal <= 1'b0;
            o_br_taken <= 1'b0;
        end else begin
            case (state_q)
                CMP: begin
                    if (!decided_q && !c_eq) begin
                        decided_q <= 1'b1;
                        less_q    <= c_lt;
                    end
                    if (last) begin
                        o_valid    <= 1'b1;
                        o_br_less  <= fin_less;
                        o_br_equal <= fin_eq;
                        o_br_taken <= br_decide(funct_q, fin_less, fin_eq);
                    end else begin
                        idx_q <= idx_q - IW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid    <= 1'b0;
                        o_br_less  <= 1'b0;
                        o_br_equal <= 1'b0;
                        o_br_taken <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Signed compares are biased by flipping the sign bit so the chunk walk stays unsigned.
            if (accept) begin
                a_q       <= i_br_un ? i_rs1_data : (i_rs1_data ^ SIGN_BIT);
                b_q       <= i_br_un ? (i_imm_sel ? i_imm : i_rs2_data)
                                     : ((i_imm_sel ? i_imm : i_rs2_data) ^ SIGN_BIT);
                funct_q   <= i_funct;
                idx_q     <= IW'(N - 1);
                decided_q <= 1'b0;
                less_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_brc_iter.sv
module tb_brc_iter;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             i_clk;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic [WIDTH-1:0] i_imm;
    logic             i_imm_sel;
    logic             i_br_un;
    logic [2:0]       i_funct;
    logic             i_flush;
    logic             o_valid;
    logic             i_ready;
    logic             o_br_less;
    logic             o_br_equal;
    logic             o_br_taken;

    int checks;
    int failures;

    logic exp_less, exp_eq, exp_taken;
    int   exp_lat;

    brc_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_imm      (i_imm),
        .i_imm_sel  (i_imm_sel),
        .i_br_un    (i_br_un),
        .i_funct    (i_funct),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_br_less  (o_br_less),
        .o_br_equal (o_br_equal),
        .o_br_taken (o_br_taken)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle of o_valid after accept: first differing chunk from the MSB with early exit, else N+1.
    function automatic int model_latency(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int first_diff;
        first_diff = -1;
        for (int k = N - 1; k >= 0; k--)
            if (x[WIDTH-1-k*CHUNK -: CHUNK] != y[WIDTH-1-k*CHUNK -: CHUNK]) first_diff = k;
`ifdef BRC_ITER_EARLY_EXIT_EN
        return (first_diff < 0) ? N + 1 : first_diff + 2;
`else
        return (first_diff < 0) ? N + 1 : N + 1;
`endif
    endfunction

    // Present a request and compute its expected result from plain arithmetic.
    task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                             input logic sel, input logic un, input logic [2:0] f);
        logic [31:0] opb;
        i_rs1_data = a;
        i_rs2_data = b;
        i_imm      = imm;
        i_imm_sel  = sel;
        i_br_un    = un;
        i_funct    = f;
        i_valid    = 1'b1;
        opb        = sel ? imm : b;
        exp_less   = un ? (a < opb) : ($signed(a) < $signed(opb));
        exp_eq     = (a == opb);
        case (f)
            3'b000:         exp_taken = exp_eq;
            3'b001:         exp_taken = ~exp_eq;
            3'b100, 3'b110: exp_taken = exp_less;
            3'b101, 3'b111: exp_taken = ~exp_less;
            default:        exp_taken = 1'b0;
        endcase
        exp_lat = model_latency(a, opb);
        #1;
        chk("acc_rdy", {31'b0, o_ready}, 32'd1);
    endtask

    // Called in the cycle the request is presented; waits for and checks the result.
    task automatic wait_result();
        int cyc;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        cyc = 1;
        while (!o_valid && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("less",  {31'b0, o_br_less},  {31'b0, exp_less});
        chk("equal", {31'b0, o_br_equal}, {31'b0, exp_eq});
        chk("taken", {31'b0, o_br_taken}, {31'b0, exp_taken});
    endtask

    task automatic hold_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_clk);
            chk("hold_vld",   {31'b0, o_valid},    32'd1);
            chk("hold_less",  {31'b0, o_br_less},  {31'b0, exp_less});
            chk("hold_taken", {31'b0, o_br_taken}, {31'b0, exp_taken});
        end
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("vld_clr", {31'b0, o_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, imm, opb;
        logic        sel;
        int          mode;
        checks = 0;
        failures = 0;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
        i_rs1_data = '0; i_rs2_data = '0; i_imm = '0; i_imm_sel = 1'b0;
        i_br_un = 1'b0; i_funct = 3'b000;

        // Reset state.
        repeat (2) @(negedge i_clk);
        chk("rst_rdy", {31'b0, o_ready}, 32'd0);
        chk("rst_vld", {31'b0, o_valid}, 32'd0);
        chk("rst_flags", {29'b0, o_br_less, o_br_equal, o_br_taken}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post_rst_rdy", {31'b0, o_ready}, 32'd1);

        // 1: signed BLT -1 < 1.
        drive_req(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 3'b100);
        wait_result();
        chk("t1_less", {31'b0, o_br_less}, 32'd1);
        chk("t1_taken", {31'b0, o_br_taken}, 32'd1);
        consume();

        // 2: same operands unsigned.
        @(negedge i_clk);
        drive_req(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 3'b110);
        wait_result();
        chk("t2_taken", {31'b0, o_br_taken}, 32'd0);
        consume();
        @(negedge i_clk);
        drive_req(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b1, 3'b111);
        wait_result();
        chk("t2_bgeu", {31'b0, o_br_taken}, 32'd1);
        consume();

        // 3: BEQ / BNE on equal operands.
        @(negedge i_clk);
        drive_req(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b000);
        wait_result();
        chk("t3_lat5", exp_lat, 32'd5);
        chk("t3_taken", {31'b0, o_br_taken}, 32'd1);
        consume();
        @(negedge i_clk);
        drive_req(32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 3'b001);
        wait_result();
        chk("t3_bne", {31'b0, o_br_taken}, 32'd0);
        consume();

        // 4: immediate operand selected over rs2.
        @(negedge i_clk);
        drive_req(32'd5, 32'd100, 32'hFFFF_FFF6, 1'b1, 1'b0, 3'b101);
        wait_result();
        chk("t4_less", {31'b0, o_br_less}, 32'd0);
        chk("t4_taken", {31'b0, o_br_taken}, 32'd1);
        consume();

        // 5: LSB-only difference, held result, then back-to-back accept.
        @(negedge i_clk);
        drive_req(32'h10, 32'h20, 32'h0, 1'b0, 1'b1, 3'b110);
        wait_result();
        chk("t5_less", {31'b0, o_br_less}, 32'd1);
        hold_check(3);
        i_ready = 1'b1;
        drive_req(32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 3'b100);
        wait_result();
        consume();

        // 6a: flush mid-compare (equal operands keep it in CMP in either build).
        @(negedge i_clk);
        drive_req(32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 3'b000);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_flush = 1'b1;
        #1;
        chk("flush_rdy0", {31'b0, o_ready}, 32'd0);
        @(negedge i_clk);
        i_flush = 1'b0;
        #1;
        chk("flush_rdy1", {31'b0, o_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("flush_novld", {31'b0, o_valid}, 32'd0);
            @(negedge i_clk);
        end

        // 6b: asynchronous reset mid-compare.
        drive_req(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("arst_outs", {27'b0, o_ready, o_valid, o_br_less, o_br_equal, o_br_taken}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("arst_rdy", {31'b0, o_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("arst_novld", {31'b0, o_valid}, 32'd0);
            @(negedge i_clk);
        end

        // Randomized requests against the arithmetic model.
        for (int t = 0; t < 150; t++) begin
            a    = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                0:       opb = $urandom;
                1:       opb = a;
                2:       opb = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
                default: opb = a ^ 32'h8000_0000;
            endcase
            sel = 1'($urandom_range(0, 1));
            b   = sel ? $urandom : opb;
            imm = sel ? opb : $urandom;
            drive_req(a, b, imm, sel, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            wait_result();
            hold_check($urandom_range(0, 2));
            consume();
            if ($urandom_range(0, 1) == 1) @(negedge i_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brc_iter.md
# brc_iter

Parametrised, multi-cycle branch comparator for the execute stage. It accepts a branch or SLT comparison through a valid/ready handshake and compares the operands CHUNK bits per cycle, from the most significant chunk down. It returns less, equal and branch-taken flags through an output valid/ready handshake. A wide core can use it in place of a single-cycle 32-bit comparator to shorten the critical path.

## Interface
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. Must divide WIDTH. N = WIDTH/CHUNK.
- i_clk  in  1  clock. All state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid & o_ready.
- i_rs1_data  in  WIDTH  operand A.
- i_rs2_data  in  WIDTH  operand B when i_imm_sel=0.
- i_imm  in  WIDTH  operand B when i_imm_sel=1 (SLTI/SLTIU).
- i_imm_sel  in  1  selects i_imm as operand B.
- i_br_un  in  1  1 = unsigned compare, 0 = signed.
- i_funct  in  3  branch funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- i_flush  in  1  synchronous abort of any in-flight request.
- o_valid  out  1  result valid.
- i_ready  in  1  result consumed when o_valid & i_ready.
- o_br_less  out  1  A < B.
- o_br_equal  out  1  A == B.
- o_br_taken  out  1  decoded branch decision. 0 for funct 010 and 011.

## Operation
- States: IDLE, CMP, DONE.
- Accept in IDLE, or in DONE when i_ready=1 (back-to-back), and only when i_flush=0.
- o_ready = (IDLE | (DONE & i_ready)) & ~i_flush & ~i_rst.
- On accept:
  - latch A = i_rs1_data and B = i_imm_sel ? i_imm : i_rs2_data;
  - if i_br_un=0, invert bit WIDTH-1 of both (bias), so every later compare is unsigned;
  - latch i_funct;
  - set idx = N-1, clear the decided flag, go to CMP.
- CMP, each cycle, looks at chunk idx:
  - If the flag is clear and the two chunks differ: less = A_chunk < B_chunk, equal = 0, set the flag.
  - If idx = 0 and the flag is still clear: less = 0, equal = 1.
  - Go to DONE when idx = 0, or on the first difference if early exit is compiled in. Otherwise decrement idx.
- On entry to DONE, register the flags:
  - o_br_taken: BEQ = equal, BNE = ~equal, BLT/BLTU = less, BGE/BGEU = ~less.
- DONE holds o_valid and all flags stable until i_ready. Then go to IDLE, or to CMP if a new request is accepted in the same cycle.
- i_flush=1 in any state:
  - next state IDLE;
  - o_valid and all flags cleared;
  - a request presented in the same cycle is not accepted.
- Reset, asynchronous:
  - state IDLE, idx 0, decided flag 0;
  - o_valid, o_br_less, o_br_equal and o_br_taken all 0;
  - o_ready 0 while i_rst is high, 1 in the first cycle after release.

## Timing
- The request is accepted in cycle 0. Chunk k is the k-th chunk counted from the MSB (k = 0..N-1).
- With early exit: first difference at chunk k gives o_valid in cycle k+2.
- Equal operands, or no early exit: o_valid in cycle N+1.
- Back-to-back operation: the next result is available no earlier than 2 cycles after the previous handshake.
- No combinational path from data inputs to outputs. o_ready depends combinationally only on state, i_ready, i_flush and i_rst.

## Configuration
- BRC_ITER_EARLY_EXIT_EN defined: CMP leaves on the first differing chunk, giving variable latency.
- BRC_ITER_EARLY_EXIT_EN undefined: CMP always runs N cycles, giving constant latency N+1. Results are identical in both cases.

## Structure
- Package brc_pkg holds:
  - the state enum (IDLE, CMP, DONE);
  - the funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU).
- Sub-module brc_chunk_cmp: combinational CHUNK-bit unsigned compare with outputs lt and eq. Instantiate it once, fed by an idx-selected chunk mux.

## Test plan
Configuration for all scenarios: WIDTH=32, CHUNK=8.
1. Signed BLT, A=0xFFFFFFFF, B=0x00000001 -> less=1, equal=0, taken=1. o_valid in cycle 2 with early exit, cycle 5 without.
2. BLTU with the same operands -> less=0, taken=0. BGEU -> taken=1.
3. BEQ, A=B=0x12345678 -> equal=1, taken=1, o_valid in cycle 5 in both configs. BNE -> taken=0.
4. SLTI, i_imm_sel=1, A=5, i_imm=0xFFFFFFF6, i_rs2_data=100, signed BGE -> less=0, taken=1. Checks that i_imm is used instead of i_rs2_data.
5. LSB-only difference, A=0x00000010, B=0x00000020, BLTU -> less=1, o_valid in cycle 5. Then:
   - hold i_ready=0 for 3 cycles -> outputs stable;
   - raise i_ready with a new i_valid in the same cycle -> accepted back-to-back.
6. Abort, with early exit compiled out:
   - i_flush in cycle 2 -> o_valid never rises, o_ready=1 in cycle 3;
   - repeat with i_rst pulsed mid-CMP -> all outputs 0 immediately.
